// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock divider controller: FSM state encoding and
// the counter command bundle. Benches and other clock controllers import these.
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_LO = 2'd1,
    ST_RUN_HI = 2'd2
  } state_e;

  typedef struct packed {
    logic load;
    logic inc;
  } cnt_cmd_t;

endpackage

// File: rtl/clk_div_ctrl_hp_counter.sv
// Half-period counter: clears on load, steps on inc, and flags the last
// cycle of the current half-period (cnt == hp-1).
module clk_div_ctrl_hp_counter
  import clk_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cnt_cmd_t         cmd,
  input  logic [WIDTH-1:0] hp,
  output logic             term
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cmd.load)     cnt_d = '0;
    else if (cmd.inc) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // hp is never 0 (saturated on accept), so hp-1 cannot wrap
  assign term = (cnt_q == hp - WIDTH'(1));

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty clock divider. Half-period changes are staged while
// running and only take effect at the falling edge, so periods are never cut.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int RESET_HP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_hp,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RST_HP = (RESET_HP < 1) ? WIDTH'(1) : WIDTH'(RESET_HP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_hp_q, active_hp_d;
  logic [WIDTH-1:0] pend_hp_q, pend_hp_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  cnt_cmd_t         cnt_cmd;
  logic             cnt_term;
  logic             period_end;
  logic             cfg_acc;
  logic [WIDTH-1:0] hp_sat;

  clk_div_ctrl_hp_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .cmd  (cnt_cmd),
    .hp   (active_hp_q),
    .term (cnt_term)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and counter control
  always_comb begin
    state_d     = state_q;
    cnt_cmd     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d      = ST_RUN_LO;
          cnt_cmd.load = 1'b1;
        end
      end
      ST_RUN_LO: begin
        if (cnt_term) begin
          state_d      = ST_RUN_HI;
          cnt_cmd.load = 1'b1;
        end else begin
          cnt_cmd.inc  = 1'b1;
        end
      end
      ST_RUN_HI: begin
        // en is only honoured here, so a full low+high period always completes
        if (cnt_term) begin
          state_d      = en ? ST_RUN_LO : ST_IDLE;
          cnt_cmd.load = 1'b1;
        end else begin
          cnt_cmd.inc  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, all derived from the next state
  always_comb begin
    clk_out_d = (state_d == ST_RUN_HI);
    tick_d    = (state_q == ST_RUN_LO) && (state_d == ST_RUN_HI);
    busy_d    = (state_d != ST_IDLE);
  end

  assign period_end = (state_q == ST_RUN_HI) && cnt_term;
  assign cfg_ready  = !pend_v_q;
  assign cfg_acc    = cfg_valid && !pend_v_q;
  assign hp_sat     = (cfg_hp == '0) ? WIDTH'(1) : cfg_hp;

  // Config staging; apply and accept are exclusive because accept needs !pend_v_q
  always_comb begin
    active_hp_d = active_hp_q;
    pend_hp_d   = pend_hp_q;
    pend_v_d    = pend_v_q;
    if (period_end && pend_v_q) begin
      active_hp_d = pend_hp_q;
      pend_v_d    = 1'b0;
    end
    if (cfg_acc) begin
      if (state_q == ST_IDLE) begin
        active_hp_d = hp_sat;
      end else begin
        pend_hp_d   = hp_sat;
        pend_v_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_hp_q <= RST_HP;
      pend_hp_q   <= '0;
      pend_v_q    <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      active_hp_q <= active_hp_d;
      pend_hp_q   <= pend_hp_d;
      pend_v_q    <= pend_v_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: expected tick cycles are queued as each
// scenario is launched and matched against observed ticks by a monitor.
module tb_clk_div_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_hp;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];
  logic prev_clk = 1'b0;

  clk_div_ctrl #(.WIDTH(WIDTH), .RESET_HP(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_hp   (cfg_hp),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Tick monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk = 1'b0;
    end else begin
      chk("tick_on_rise", 32'(tick), 32'(clk_out && !prev_clk));
      if (tick === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_tick", cyc, 32'hFFFF_FFFF);
        else                   chk("tick_cycle", cyc, exp_q.pop_front());
      end
      prev_clk = clk_out;
    end
  end

  task automatic cfg_idle(input int hp);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_hp    = WIDTH'(hp);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("idle_cfg_ready", 32'(cfg_ready), 1);
  endtask

  // Drop en dly cycles after the last expected tick tl; high must still last hp
  task automatic stop_at(input int tl, input int hp, input int dly);
    while (cyc < tl + dly) @(negedge clk);
    en = 1'b0;
    while (cyc < tl + hp - 1) @(negedge clk);
    chk("hi_hold", 32'(clk_out), 1);
    chk("busy_hold", 32'(busy), 1);
    @(negedge clk);
    chk("fall", 32'(clk_out), 0);
    chk("busy_off", 32'(busy), 0);
    repeat (2 * hp + 2) @(negedge clk);
    chk("q_drained", exp_q.size(), 0);
    chk("idle_low", 32'(clk_out), 0);
  endtask

  task automatic run(input int hp, input int n, input int dly);
    int c0;
    @(negedge clk);
    c0 = cyc;
    en = 1'b1;
    chk("busy_before", 32'(busy), 0);
    for (int k = 0; k < n; k++) exp_q.push_back(c0 + 1 + hp + 2 * hp * k);
    @(negedge clk);
    chk("busy_run", 32'(busy), 1);
    chk("lo_first", 32'(clk_out), 0);
    stop_at(c0 + 1 + hp + 2 * hp * (n - 1), hp, dly);
  endtask

  initial begin
    int c0, t1;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_hp = '0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset half-period 1: clk/2
    run(1, 4, 0);

    // hp=3 configured in IDLE: period 6
    cfg_idle(3);
    run(3, 3, 0);

    // Reconfigure to 5 during the high phase of an hp=3 period
    cfg_idle(3);
    @(negedge clk);
    c0 = cyc; en = 1'b1; t1 = c0 + 4;
    exp_q.push_back(t1); exp_q.push_back(t1 + 8); exp_q.push_back(t1 + 18);
    while (cyc < t1) @(negedge clk);
    chk("s3_hi", 32'(clk_out), 1);
    cfg_valid = 1'b1; cfg_hp = 8'd5;
    chk("s3_ready_pre", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("s3_ready_pend1", 32'(cfg_ready), 0);
    @(negedge clk);
    chk("s3_ready_pend2", 32'(cfg_ready), 0);
    chk("s3_hi_kept", 32'(clk_out), 1);
    @(negedge clk);
    chk("s3_ready_back", 32'(cfg_ready), 1);
    chk("s3_fall", 32'(clk_out), 0);
    stop_at(t1 + 18, 5, 0);

    // cfg_hp=0 saturates to 1
    cfg_idle(0);
    run(1, 3, 0);

    // hp=4, en dropped one cycle into the high phase
    cfg_idle(4);
    run(4, 2, 1);

    // Accept on the very edge that ends a period: lands in pending
    cfg_idle(2);
    @(negedge clk);
    c0 = cyc; en = 1'b1; t1 = c0 + 3;
    exp_q.push_back(t1); exp_q.push_back(t1 + 4);
    exp_q.push_back(t1 + 9); exp_q.push_back(t1 + 15);
    while (cyc < t1 + 1) @(negedge clk);
    cfg_valid = 1'b1; cfg_hp = 8'd3;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("s6_fall", 32'(clk_out), 0);
    chk("s6_ready_pend", 32'(cfg_ready), 0);
    while (cyc < t1 + 5) @(negedge clk);
    chk("s6_ready_hold", 32'(cfg_ready), 0);
    @(negedge clk);
    chk("s6_ready_back", 32'(cfg_ready), 1);
    stop_at(t1 + 15, 3, 0);

    // Async reset mid high phase with a pending config
    cfg_idle(4);
    @(negedge clk);
    c0 = cyc; en = 1'b1; t1 = c0 + 5;
    exp_q.push_back(t1);
    while (cyc < t1) @(negedge clk);
    cfg_valid = 1'b1; cfg_hp = 8'd6;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("s7_ready_pend", 32'(cfg_ready), 0);
    chk("s7_hi", 32'(clk_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s7_rst_clk_out", 32'(clk_out), 0);
    chk("s7_rst_ready", 32'(cfg_ready), 1);
    chk("s7_rst_busy", 32'(busy), 0);
    chk("s7_rst_tick", 32'(tick), 0);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("s7_q_drained", exp_q.size(), 0);
    // Restart must run at RESET_HP; a surviving pending 6 would stretch period 2
    run(1, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
